prbs9_gen: RTL

PRBS9_GEN -- requirements
Module: prbs9_gen

---
 rtl/prbs9_pkg.sv | 12 +
 rtl/prbs9_gen.sv | 105 ++++++++++
 2 files changed

// File: rtl/prbs9_pkg.sv
// prbs9_pkg: constants shared by the PRBS9 generator and the BER checker.
//   PRBS_ORDER - LFSR length in bits
//   PRBS_LEN   - sequence period (2^9 - 1)
//   TAP_HI/LO  - feedback tap positions for x^9 + x^5 + 1
package prbs9_pkg;
    localparam int PRBS_ORDER = 9;
    localparam int PRBS_LEN   = 511;
    localparam int TAP_HI     = 8;
    localparam int TAP_LO     = 4;

    typedef logic [PRBS_ORDER-1:0] prbs_state_t;
endpackage

// File: rtl/prbs9_gen.sv
// prbs9_gen: oversampled PRBS9 source with optional single-bit error injection.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   i_enable   - run/stop; low holds the generator at the start of the sequence
//   i_err_inj  - when high, bit index ERR_IDX of each period is inverted
//   o_bit      - PRBS9 data bit (held between strobes)
//   o_valid    - one-cycle strobe for each new o_bit (every OS_FACTOR clocks)
//   o_sync     - strobes with o_valid on bit index 0
//   o_bit_idx  - index 0..510 of the current o_bit
module prbs9_gen
    import prbs9_pkg::*;
#(
    parameter logic [8:0] SEED      = 9'h1FF,
    parameter int          OS_FACTOR = 4,
    parameter logic [8:0] ERR_IDX   = 9'd100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_enable,
    input  logic       i_err_inj,
    output logic       o_bit,
    output logic       o_valid,
    output logic       o_sync,
    output logic [8:0] o_bit_idx
);

    localparam int                DIV_W    = $clog2(OS_FACTOR);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(OS_FACTOR - 1);
    localparam logic [8:0]        IDX_LAST = 9'(PRBS_LEN - 1);

    // Left-shift LFSR for x^9 + x^5 + 1; the new bit enters at bit 0.
    function automatic prbs_state_t lfsr_next(input prbs_state_t s);
        return {s[PRBS_ORDER-2:0], s[TAP_HI] ^ s[TAP_LO]};
    endfunction

    prbs_state_t      lfsr_q, lfsr_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [8:0]       idx_q, idx_d;
    logic             bit_q, bit_d;
    logic             valid_q, valid_d;
    logic             sync_q, sync_d;
    logic [8:0]       bit_idx_q, bit_idx_d;
    logic             step;
    logic             inj;

    always_comb begin
        lfsr_d    = lfsr_q;
        div_cnt_d = div_cnt_q;
        idx_d     = idx_q;
        bit_d     = bit_q;
        valid_d   = 1'b0;
        sync_d    = 1'b0;
        bit_idx_d = bit_idx_q;
        step      = 1'b0;
        inj       = 1'b0;

        if (!i_enable) begin
            // Disabled: park at the start of the sequence so the next enable
            // restarts from SEED at index 0.
            lfsr_d    = SEED;
            div_cnt_d = '0;
            idx_d     = '0;
        end else begin
            step      = (div_cnt_q == DIV_LAST);
            div_cnt_d = step ? '0 : div_cnt_q + 1'b1;
            if (step) begin
                // Injection only touches the emitted bit, never the LFSR.
                inj       = i_err_inj && (idx_q == ERR_IDX);
                bit_d     = lfsr_q[TAP_HI] ^ inj;
                valid_d   = 1'b1;
                sync_d    = (idx_q == '0);
                bit_idx_d = idx_q;
                lfsr_d    = (lfsr_q == '0) ? SEED : lfsr_next(lfsr_q);
                idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q    <= SEED;
            div_cnt_q <= '0;
            idx_q     <= '0;
            bit_q     <= 1'b0;
            valid_q   <= 1'b0;
            sync_q    <= 1'b0;
            bit_idx_q <= '0;
        end else begin
            lfsr_q    <= lfsr_d;
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            bit_q     <= bit_d;
            valid_q   <= valid_d;
            sync_q    <= sync_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    assign o_bit     = bit_q;
    assign o_valid   = valid_q;
    assign o_sync    = sync_q;
    assign o_bit_idx = bit_idx_q;

endmodule
